jk_bank_scheduler: RTL and testbench
====================================

# jk_bank_scheduler

Shares a bank of negative-edge JK flip-flops between several requesters. Each requester asks for one operation (hold/read, reset, set, toggle) on one flop; a round-robin arbiter picks one request at a time. The scheduler drives that flop's j/k pins for exactly one clock period, which spans the flop's falling edge, and returns the flop's new q to the requester. It sits between the control logic and the JK flop bank, and owns every j/k pin in the bank.

## Interface
- NREQ, 4, number of requesters (2..8)
- NFF, 8, number of JK flops in the bank
- AW, $clog2(NFF), flop address width
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-low reset
- req  in  NREQ  per-requester request level
- op  in  2*NREQ  per-requester op, slice [2i+1:2i]
- addr  in  AW*NREQ  per-requester flop index, slice [AW*i+AW-1:AW*i]
- q_bus  in  NFF  q outputs of the flop bank
- gnt  out  NREQ  one-hot, one-cycle acceptance pulse
- done  out  NREQ  one-hot, one-cycle completion pulse
- rdata  out  1  q of the addressed flop after the op; valid while done is high
- j_bus  out  NFF  j pins of the flop bank
- k_bus  out  NFF  k pins of the flop bank
- busy  out  1  high in every state except IDLE

## Operation
- Op encoding: 00 HOLD/read (j=0, k=0), 01 RESET (j=0, k=1), 10 SET (j=1, k=0), 11 TOGGLE (j=1, k=1).
- States: IDLE, DRIVE, DONE. All outputs are registered.
- IDLE
  - If no req bit is high, stay in IDLE.
  - Otherwise the arbiter selects a winner; its op and addr are latched, its gnt bit pulses, and the state moves to DRIVE.
- Arbitration: round-robin. Search starts at (last winner + 1) mod NREQ. The pointer updates only on a grant.
- DRIVE
  - j_bus[addr] and k_bus[addr] carry the op's values; every other bit is 0.
  - Next state is DONE.
  - On the DRIVE→DONE edge, rdata is loaded with q_bus[addr].
- DONE
  - j_bus and k_bus are all 0; the winner's done bit is high.
  - Next state is IDLE.
- Requester rules
  - Hold req, op and addr stable from assertion until done.
  - Deassert req in the cycle after done, otherwise the request is taken as new.
  - op and addr are sampled only at the IDLE→DRIVE edge.
- A req that drops before it is granted is simply lost; no error is raised.
- An out-of-range addr (≥ NFF) drives no pin, and rdata = 0.
- Reset (rst=0 at any rising edge)
  - State goes to IDLE; gnt, done, j_bus, k_bus, rdata and busy all go to 0; the pointer goes to NREQ-1, so requester 0 has priority first.
  - An in-flight op is abandoned with no done. If reset lands in DRIVE, the flop may already have changed; the flop bank has its own reset.

## Timing
- Request first sampled at edge E0 (in IDLE) → gnt and j/k driven during cycle E0–E1.
- The flop updates on the falling edge in mid-cycle; q_bus is sampled at E1.
- done and rdata are high during E1–E2. busy is high from E0 to E2.
- Back in IDLE at E2; the next grant is possible at E3.
- Throughput: one op per 3 cycles. Request-to-done latency: 2 cycles.
- j/k are never asserted for more than one cycle, and are never asserted on two flops at once.

## Structure
- Package jk_sched_pkg holds:
  - op localparams OP_HOLD, OP_RST, OP_SET, OP_TGL
  - state encoding ST_IDLE, ST_DRIVE, ST_DONE
- Sub-module rr_arbiter: combinational. Inputs are req and the pointer; outputs are a one-hot winner and its index. It is instantiated once.
- The flop bank itself is outside this block.

## Test plan
- Reset: hold rst=0 for 2 cycles with req=4'b1111 → gnt=0, done=0, j_bus=k_bus=0, busy=0. The first grant after release goes to requester 0.
- Single op: req[1]=1, op=10, addr=3, flop 3 initially 0.
  - gnt=0010 for one cycle, with j_bus=8'h08 and k_bus=0 in that cycle.
  - Next cycle: done=0010, rdata=1.
- Toggle then read: TOGGLE on flop 5 (q=1) → rdata=0. A following HOLD on flop 5 → rdata=0, and j_bus=k_bus=0 throughout.
- Round-robin: all four req held high, each dropped after its done → grant order 0,1,2,3. Re-raising req0 and req2 gives order 0,2. No requester is granted twice while another waits.
- Reset mid-op: rst=0 during DRIVE → next cycle is IDLE, done never pulses, and j_bus=k_bus=0.
- Boundary: addr=NFF with op=11 → j_bus=k_bus=0, done pulses, rdata=0.

Source files
------------

// File: rtl/jk_sched_pkg.sv
// Shared op codes, FSM states and j/k decode for the JK flop bank scheduler.
// Pure definitions: no latency, no flow control.
package jk_sched_pkg;

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_RST  = 2'b01;
    localparam logic [1:0] OP_SET  = 2'b10;
    localparam logic [1:0] OP_TGL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Returns {j, k} for an op.
    function automatic logic [1:0] op_to_jk(input logic [1:0] op);
        logic [1:0] jk;
        case (op)
            OP_RST:  jk = 2'b01;
            OP_SET:  jk = 2'b10;
            OP_TGL:  jk = 2'b11;
            default: jk = 2'b00;
        endcase
        return jk;
    endfunction

endpackage

// File: rtl/jk_bank_scheduler_if.sv
// Requester and flop-bank signals of the JK bank scheduler.
// master = control logic plus flop bank q outputs; slave = the scheduler.
interface jk_bank_scheduler_if #(
    parameter int NREQ = 4,
    parameter int NFF  = 8,
    parameter int AW   = $clog2(NFF)
);
    logic [NREQ-1:0]    req;
    logic [2*NREQ-1:0]  op;
    logic [AW*NREQ-1:0] addr;
    logic [NFF-1:0]     q_bus;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic               rdata;
    logic [NFF-1:0]     j_bus;
    logic [NFF-1:0]     k_bus;
    logic               busy;

    modport master (
        output req, op, addr, q_bus,
        input  gnt, done, rdata, j_bus, k_bus, busy
    );

    modport slave (
        input  req, op, addr, q_bus,
        output gnt, done, rdata, j_bus, k_bus, busy
    );
endinterface

// File: rtl/jk_bank_scheduler_rr_arbiter.sv
// Combinational round-robin pick: lowest distance above ptr wins.
// Zero latency; no backpressure, caller decides when the pick is taken.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic [IW-1:0]   win_idx,
    output logic            hit
);

    int best_d;
    int d;

    // Distance 0 is the slot right after the last winner.
    always_comb begin
        best_d  = NREQ;
        d       = 0;
        win_idx = '0;
        for (int j = 0; j < NREQ; j++) begin
            d = (j - int'(ptr) - 1 + 2 * NREQ) % NREQ;
            if (req[j] && d < best_d) begin
                best_d  = d;
                win_idx = IW'(j);
            end
        end
        hit = (best_d < NREQ);
        win = hit ? (NREQ'(1) << win_idx) : '0;
    end

endmodule

// File: rtl/jk_bank_scheduler.sv
// Time-shares a negedge JK flop bank among NREQ requesters, one op per 3 cycles.
// Request-to-done 2 cycles; requests wait at req until granted, no other stall.
module jk_bank_scheduler
    import jk_sched_pkg::*;
#(
    parameter  int NREQ = 4,
    parameter  int NFF  = 8,
    parameter  int AW   = $clog2(NFF),
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input logic                clk,
    input logic                rst,
    jk_bank_scheduler_if.slave bus
);

    state_t          state, state_nxt;
    logic [IW-1:0]   ptr;
    logic [NREQ-1:0] win;
    logic [IW-1:0]   win_idx;
    logic            hit;

    logic [1:0]      w_op;
    logic [AW-1:0]   w_addr;
    logic [NREQ-1:0] cur_win;
    logic [AW-1:0]   cur_addr;

    logic [NREQ-1:0] gnt_q, gnt_nxt;
    logic [NREQ-1:0] done_q, done_nxt;
    logic [NFF-1:0]  j_q, j_nxt;
    logic [NFF-1:0]  k_q, k_nxt;
    logic            rdata_q, rdata_nxt;
    logic            busy_q, busy_nxt;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req     (bus.req),
        .ptr     (ptr),
        .win     (win),
        .win_idx (win_idx),
        .hit     (hit)
    );

    always_comb begin
        w_op   = '0;
        w_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win[i]) begin
                w_op   = bus.op[2*i +: 2];
                w_addr = bus.addr[AW*i +: AW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (hit) state_nxt = ST_DRIVE;
            ST_DRIVE: state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Out-of-range addresses match no flop, so they drive nothing and read 0.
    always_comb begin
        gnt_nxt   = '0;
        done_nxt  = '0;
        j_nxt     = '0;
        k_nxt     = '0;
        rdata_nxt = rdata_q;
        busy_nxt  = (state_nxt != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (hit) begin
                    gnt_nxt = win;
                    for (int f = 0; f < NFF; f++) begin
                        if (int'(w_addr) == f) {j_nxt[f], k_nxt[f]} = op_to_jk(w_op);
                    end
                end
            end
            ST_DRIVE: begin
                done_nxt  = cur_win;
                rdata_nxt = 1'b0;
                for (int f = 0; f < NFF; f++) begin
                    if (int'(cur_addr) == f) rdata_nxt = bus.q_bus[f];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr      <= IW'(NREQ - 1);
            cur_win  <= '0;
            cur_addr <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            j_q      <= '0;
            k_q      <= '0;
            rdata_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            if (state == ST_IDLE && hit) begin
                ptr      <= win_idx;
                cur_win  <= win;
                cur_addr <= w_addr;
            end
            gnt_q   <= gnt_nxt;
            done_q  <= done_nxt;
            j_q     <= j_nxt;
            k_q     <= k_nxt;
            rdata_q <= rdata_nxt;
            busy_q  <= busy_nxt;
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.done  = done_q;
    assign bus.j_bus = j_q;
    assign bus.k_bus = k_q;
    assign bus.rdata = rdata_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_jk_bank_scheduler.sv
// Bench for jk_bank_scheduler: transaction-timeline model, negedge flop bank,
// directed scenarios then randomized requesters with occasional resets.
module tb_jk_bank_scheduler;
    import jk_sched_pkg::*;

    localparam int NREQ = 4;
    localparam int NFF  = 8;
    localparam int AW   = 4;
    localparam logic [NFF-1:0] FB_INIT = 8'h20;

    logic clk;
    logic rst;
    logic fb_rst;
    logic [NFF-1:0] fq;

    int checks = 0;
    int errors = 0;

    jk_bank_scheduler_if #(.NREQ(NREQ), .NFF(NFF), .AW(AW)) bus ();

    jk_bank_scheduler #(.NREQ(NREQ), .NFF(NFF), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External negedge JK flop bank
    always @(negedge clk) begin
        if (fb_rst) fq <= FB_INIT;
        else begin
            for (int f = 0; f < NFF; f++) begin
                case ({bus.j_bus[f], bus.k_bus[f]})
                    2'b01:   fq[f] <= 1'b0;
                    2'b10:   fq[f] <= 1'b1;
                    2'b11:   fq[f] <= ~fq[f];
                    default: fq[f] <= fq[f];
                endcase
            end
        end
    end
    assign bus.q_bus = fq;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: one transaction timeline. Grant at edge g, done one cycle later,
    // next grant no earlier than g+3.
    int cyc = 0;
    int g_cyc = -100;
    int free_at = 0;
    int mptr = NREQ - 1;
    int m_w = 0;
    int cand;
    bit started = 0;
    logic [NFF-1:0] mq;
    logic [NFF-1:0] m_j, m_k;
    logic m_rd;
    logic [1:0] m_op;
    logic [AW-1:0] m_a;

    always @(posedge clk) begin
        cyc++;
        if (fb_rst) mq = FB_INIT;
        if (!rst) begin
            started = 1;
            g_cyc   = -100;
            mptr    = NREQ - 1;
            free_at = cyc + 1;
        end else if (started && cyc >= free_at && bus.req != 0) begin
            for (int s = 1; s <= NREQ; s++) begin
                cand = (mptr + s) % NREQ;
                if (bus.req[cand]) begin
                    m_w = cand;
                    break;
                end
            end
            m_op = bus.op[2*m_w +: 2];
            m_a  = bus.addr[AW*m_w +: AW];
            m_j  = '0;
            m_k  = '0;
            m_rd = 1'b0;
            if (int'(m_a) < NFF) begin
                case (m_op)
                    OP_RST:  begin m_k[m_a] = 1'b1; mq[m_a] = 1'b0; end
                    OP_SET:  begin m_j[m_a] = 1'b1; mq[m_a] = 1'b1; end
                    OP_TGL:  begin m_j[m_a] = 1'b1; m_k[m_a] = 1'b1; mq[m_a] = ~mq[m_a]; end
                    default: ;
                endcase
                m_rd = mq[m_a];
            end
            g_cyc   = cyc;
            free_at = cyc + 3;
            mptr    = m_w;
        end
    end

    logic [NREQ-1:0] exp_g, exp_d;
    logic [NFF-1:0]  exp_j, exp_k;
    logic            exp_b;

    always @(negedge clk) begin
        if (started) begin
            exp_g = '0; exp_d = '0; exp_j = '0; exp_k = '0; exp_b = 1'b0;
            if (cyc == g_cyc) begin
                exp_g = NREQ'(1) << m_w;
                exp_j = m_j;
                exp_k = m_k;
                exp_b = 1'b1;
            end else if (cyc == g_cyc + 1) begin
                exp_d = NREQ'(1) << m_w;
                exp_b = 1'b1;
            end
            chk("model_gnt",  32'(bus.gnt),   32'(exp_g));
            chk("model_done", 32'(bus.done),  32'(exp_d));
            chk("model_j",    32'(bus.j_bus), 32'(exp_j));
            chk("model_k",    32'(bus.k_bus), 32'(exp_k));
            chk("model_busy", 32'(bus.busy),  32'(exp_b));
            if (cyc == g_cyc + 1) chk("model_rdata", 32'(bus.rdata), 32'(m_rd));
        end
    end

    // One op from a single requester; caller is at a negedge with the DUT idle or finishing.
    task automatic do_op(input int r, input logic [1:0] o, input logic [AW-1:0] a,
                         output logic [NREQ-1:0] g, output logic [NFF-1:0] j,
                         output logic [NFF-1:0] k, output logic [NREQ-1:0] d,
                         output logic rd);
        bit seen;
        seen = 0;
        g = '0; j = '0; k = '0; d = '0; rd = 1'b0;
        bus.op[2*r +: 2]    = o;
        bus.addr[AW*r +: AW] = a;
        bus.req[r]          = 1'b1;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            if (bus.gnt != 0) begin
                seen = 1;
                g = bus.gnt; j = bus.j_bus; k = bus.k_bus;
            end
        end
        if (!seen) chk("do_op_grant_timeout", 32'd1, 32'd0);
        @(negedge clk);
        d  = bus.done;
        rd = bus.rdata;
        bus.req[r] = 1'b0;
    endtask

    task automatic collect(input int want, output int ord[$]);
        ord.delete();
        for (int t = 0; t < 40 && !(ord.size() == want && bus.req == 0); t++) begin
            @(negedge clk);
            if (bus.gnt != 0) ord.push_back($clog2(bus.gnt));
            if (bus.done != 0) bus.req = bus.req & ~bus.done;
        end
        chk("rr_grant_count", 32'(ord.size()), 32'(want));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    logic [NREQ-1:0] g, d;
    logic [NFF-1:0]  j, k;
    logic            rd;
    int              ord[$];
    bit              pend[NREQ];

    initial begin
        rst = 1'b0; fb_rst = 1'b1;
        bus.req = 4'hF; bus.op = '0; bus.addr = '0;
        repeat (2) @(negedge clk);
        chk("rst_gnt",  32'(bus.gnt),   32'h0);
        chk("rst_done", 32'(bus.done),  32'h0);
        chk("rst_j",    32'(bus.j_bus), 32'h0);
        chk("rst_k",    32'(bus.k_bus), 32'h0);
        chk("rst_busy", 32'(bus.busy),  32'h0);
        fb_rst = 1'b0;
        rst = 1'b1;

        collect(4, ord);
        for (int i = 0; i < ord.size(); i++) chk("rr_order_all4", 32'(ord[i]), 32'(i));
        bus.req = 4'b0101;
        collect(2, ord);
        if (ord.size() == 2) begin
            chk("rr_order_02_first",  32'(ord[0]), 32'd0);
            chk("rr_order_02_second", 32'(ord[1]), 32'd2);
        end

        do_op(1, OP_SET, 4'd3, g, j, k, d, rd);
        chk("set_gnt",   32'(g),  32'h2);
        chk("set_j",     32'(j),  32'h08);
        chk("set_k",     32'(k),  32'h00);
        chk("set_done",  32'(d),  32'h2);
        chk("set_rdata", 32'(rd), 32'h1);

        do_op(2, OP_TGL, 4'd5, g, j, k, d, rd);
        chk("tgl_j",     32'(j),  32'h20);
        chk("tgl_k",     32'(k),  32'h20);
        chk("tgl_rdata", 32'(rd), 32'h0);
        do_op(2, OP_HOLD, 4'd5, g, j, k, d, rd);
        chk("hold_j",     32'(j),  32'h0);
        chk("hold_k",     32'(k),  32'h0);
        chk("hold_rdata", 32'(rd), 32'h0);

        do_op(3, OP_TGL, 4'd8, g, j, k, d, rd);
        chk("oob_j",     32'(j),  32'h0);
        chk("oob_k",     32'(k),  32'h0);
        chk("oob_done",  32'(d),  32'h8);
        chk("oob_rdata", 32'(rd), 32'h0);

        // Reset lands while the op is in DRIVE
        @(negedge clk);
        bus.op[1:0] = OP_SET; bus.addr[AW-1:0] = 4'd1; bus.req[0] = 1'b1;
        @(negedge clk);
        chk("mid_gnt", 32'(bus.gnt), 32'h1);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_busy", 32'(bus.busy),  32'h0);
        chk("mid_j",    32'(bus.j_bus), 32'h0);
        chk("mid_k",    32'(bus.k_bus), 32'h0);
        bus.req = '0; rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("mid_no_done", 32'(bus.done), 32'h0);
        end

        for (int r = 0; r < NREQ; r++) pend[r] = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (!rst) rst = 1'b1;
            else if ($urandom_range(0, 299) == 0) begin
                rst = 1'b0;
                bus.req = '0;
                for (int r = 0; r < NREQ; r++) pend[r] = 0;
            end else begin
                for (int r = 0; r < NREQ; r++) begin
                    if (pend[r]) begin
                        if (bus.done[r]) begin bus.req[r] = 1'b0; pend[r] = 0; end
                    end else if (bus.req[r]) begin
                        if (bus.gnt[r]) pend[r] = 1;
                        else if ($urandom_range(0, 15) == 0) bus.req[r] = 1'b0;
                    end else if ($urandom_range(0, 3) == 0) begin
                        bus.op[2*r +: 2]     = 2'($urandom_range(0, 3));
                        bus.addr[AW*r +: AW] = AW'($urandom_range(0, NFF + 1));
                        bus.req[r]           = 1'b1;
                    end
                end
            end
        end
        bus.req = '0;
        rst = 1'b1;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
